// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic logic [4:0] onehot2bin(input logic [31:0] oh);
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) b = b | i[4:0];
        end
        return b;
    endfunction

    // Rotate a one-hot vector left by one position within its low n bits.
    function automatic logic [31:0] rotl1(input logic [31:0] v, input int unsigned n);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << n) - 64'd1;
        r = (({32'd0, v} << 1) | ({32'd0, v} >> (n - 1))) & m;
        return r[31:0];
    endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Requester/downstream bundle of the weighted round-robin arbiter.
// The lock vector exists only when WRR_LOCK_EN is defined.
interface wrr_arbiter_if #(
    parameter int NUM      = 4,
    parameter int WEIGHT_W = 3
) ();
    localparam int IDX_W = $clog2(NUM);

    logic [NUM-1:0]          req;
    logic [NUM*WEIGHT_W-1:0] weight;
    logic                    ack;
    logic [NUM-1:0]          gnt;
    logic                    gnt_valid;
    logic [IDX_W-1:0]        gnt_idx;
`ifdef WRR_LOCK_EN
    logic [NUM-1:0]          lock;
`endif

    modport master (
        output req, weight, ack,
`ifdef WRR_LOCK_EN
        output lock,
`endif
        input  gnt, gnt_valid, gnt_idx
    );

    modport slave (
        input  req, weight, ack,
`ifdef WRR_LOCK_EN
        input  lock,
`endif
        output gnt, gnt_valid, gnt_idx
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above base, wrapping.
module rr_pick #(
    parameter int NUM = 4
) (
    input  logic [NUM-1:0] base,
    input  logic [NUM-1:0] request,
    output logic [NUM-1:0] pick
);
    logic [2*NUM-1:0] dbl;
    logic [2*NUM-1:0] dgnt;

    // Subtracting the one-hot base clears everything below it and isolates
    // the first request at or after it; the upper copy covers the wrap.
    assign dbl  = {request, request};
    assign dgnt = dbl & ~(dbl - {{NUM{1'b0}}, base});
    assign pick = dgnt[NUM-1:0] | dgnt[2*NUM-1:NUM];
endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered grant and per-tenure beat budget.
// Define WRR_LOCK_EN to add the lock input that holds a tenure past its budget.
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int NUM      = 4,
    parameter int WEIGHT_W = 3,
    parameter int IDX_W    = $clog2(NUM)
) (
    input logic          clk,
    input logic          reset_n,
    wrr_arbiter_if.slave bus
);
    state_t              state;
    logic [NUM-1:0]      ptr;
    logic [WEIGHT_W-1:0] credit;

    logic [31:0]         gnt_w;
    logic [31:0]         rot_w;
    logic [NUM-1:0]      base_nxt;
    logic [NUM-1:0]      pick_base;
    logic [NUM-1:0]      pick;
    logic [31:0]         pick_w;
    logic [4:0]          pick_bin;
    logic [IDX_W-1:0]    pick_idx;
    logic [WEIGHT_W-1:0] load;
    logic                owner_req;
    logic                lock_hold;
    logic                beat;
    logic                spent;
    logic                rel;

    always_comb begin
        gnt_w            = '0;
        gnt_w[NUM-1:0]   = bus.gnt;
        rot_w            = rotl1(gnt_w, NUM);
        base_nxt         = rot_w[NUM-1:0];
        owner_req        = |(bus.gnt & bus.req);
`ifdef WRR_LOCK_EN
        lock_hold        = |(bus.gnt & bus.lock);
`else
        lock_hold        = 1'b0;
`endif
        beat             = (state == GRANT) && owner_req && bus.ack;
        spent            = beat && (credit == WEIGHT_W'(1)) && !lock_hold;
        rel              = (state == GRANT) && (spent || !owner_req);
        // After the pointer advances past the owner, the owner is last in
        // wrapped order, so an unmasked pick already prefers every other
        // requester and falls back to the owner only when it is alone.
        pick_base        = (state == GRANT) ? base_nxt : ptr;
    end

    rr_pick #(.NUM(NUM)) u_pick (
        .base    (pick_base),
        .request (bus.req),
        .pick    (pick)
    );

    always_comb begin
        pick_w          = '0;
        pick_w[NUM-1:0] = pick;
        pick_bin        = onehot2bin(pick_w);
        pick_idx        = pick_bin[IDX_W-1:0];
        load            = '0;
        for (int i = 0; i < NUM; i++) begin
            if (pick[i]) load = bus.weight[i*WEIGHT_W +: WEIGHT_W];
        end
        if (load == '0) load = WEIGHT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= NUM'(1);
            credit        <= '0;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pick) begin
                        bus.gnt       <= pick;
                        bus.gnt_valid <= 1'b1;
                        bus.gnt_idx   <= pick_idx;
                        credit        <= load;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr <= base_nxt;
                        if (|pick) begin
                            bus.gnt       <= pick;
                            bus.gnt_valid <= 1'b1;
                            bus.gnt_idx   <= pick_idx;
                            credit        <= load;
                        end else begin
                            bus.gnt       <= '0;
                            bus.gnt_valid <= 1'b0;
                            bus.gnt_idx   <= '0;
                            credit        <= '0;
                            state         <= IDLE;
                        end
                    end else if (beat && credit != WEIGHT_W'(1)) begin
                        // A locked owner at credit 1 keeps beating with credit held.
                        credit <= credit - WEIGHT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus random traffic
// checked against a behavioural owner/credit/pointer model.
module tb_wrr_arbiter;
    localparam int NUM = 4;
    localparam int WW  = 3;

    logic clk = 1'b0;
    logic reset_n;

    wrr_arbiter_if #(.NUM(NUM), .WEIGHT_W(WW)) bus ();

    wrr_arbiter #(.NUM(NUM), .WEIGHT_W(WW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int m_owner;
    int m_credit;
    int m_ptr;
    int beat_owner;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wt(input int i);
        int w;
        w = int'(bus.weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int search(input int from);
        for (int k = 0; k < NUM; k++) begin
            if (bus.req[(from + k) % NUM]) return (from + k) % NUM;
        end
        return -1;
    endfunction

    function automatic bit locked(input int o);
`ifdef WRR_LOCK_EN
        return bus.lock[o];
`else
        return (o < 0);
`endif
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_credit = 0;
        m_ptr    = 0;
    endtask

    task automatic model_step();
        int  o;
        int  w;
        bit  rel;
        if (m_owner < 0) begin
            w = search(m_ptr);
            if (w >= 0) begin
                m_owner  = w;
                m_credit = wt(w);
            end
        end else begin
            o   = m_owner;
            rel = 1'b0;
            if (!bus.req[o]) rel = 1'b1;
            else if (bus.ack) begin
                if (m_credit == 1 && !locked(o)) rel = 1'b1;
                else if (m_credit > 1) m_credit--;
            end
            if (rel) begin
                m_ptr    = (o + 1) % NUM;
                w        = search(m_ptr);
                m_owner  = w;
                m_credit = (w >= 0) ? wt(w) : 0;
            end
        end
    endtask

    task automatic cycle();
        beat_owner = -1;
        if (bus.gnt_valid && bus.ack) begin
            for (int i = 0; i < NUM; i++) begin
                if (bus.gnt[i] && bus.req[i]) beat_owner = i;
            end
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("gnt",       32'(bus.gnt),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("gnt_valid", 32'(bus.gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
        check("gnt_idx",   32'(bus.gnt_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_gnt",       32'(bus.gnt),       32'd0);
        check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int exp_seq[8];
    int nb;

    initial begin
        reset_n    = 1'b0;
        bus.req    = '0;
        bus.ack    = 1'b0;
        bus.weight = '0;
`ifdef WRR_LOCK_EN
        bus.lock   = '0;
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("init_gnt",       32'(bus.gnt),       32'd0);
        check("init_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("init_gnt_idx",   32'(bus.gnt_idx),   32'd0);
        reset_n = 1'b1;

        // Async reset mid-tenure, then first grant goes to requester 0.
        bus.req    = 4'b1111;
        bus.weight = {3'd1, 3'd1, 3'd1, 3'd1};
        cycle();
        cycle();
        do_reset();
        cycle();
        check("rst_first_gnt", 32'(bus.gnt), 32'd1);

        // Weights {1,2,3,1} with continuous ack: back-to-back beats.
        bus.weight = {3'd1, 3'd3, 3'd2, 3'd1};
        bus.ack    = 1'b1;
        do_reset();
        exp_seq = '{0, 1, 1, 2, 2, 2, 3, 0};
        cycle();
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("wrr_beat", 32'(beat_owner), 32'(exp_seq[i]));
        end

        // Backpressure on a sole requester, then pointer advance.
        bus.req    = 4'b0100;
        bus.weight = {3'd0, 3'd2, 3'd0, 3'd0};
        bus.ack    = 1'b0;
        do_reset();
        cycle();
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            check("bp_gnt_hold", 32'(bus.gnt), 32'h4);
            bus.ack = (i != 1);
            if (i == 2) bus.req = 4'b0110;
            cycle();
            if (beat_owner == 2) nb++;
        end
        check("bp_beats", 32'(nb), 32'd2);
        check("bp_ptr_next", 32'(bus.gnt), 32'h2);

        // Owner withdraws after one beat; requester 2 takes over with its own budget.
        bus.req    = 4'b0110;
        bus.weight = {3'd0, 3'd2, 3'd3, 3'd0};
        bus.ack    = 1'b1;
        do_reset();
        cycle();
        cycle();
        bus.req = 4'b0100;
        cycle();
        check("withdraw_gnt", 32'(bus.gnt), 32'h4);
        bus.req = 4'b0110;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.gnt == 4'b0100) begin
                cycle();
                if (beat_owner == 2) nb++;
            end
        end
        check("withdraw_credit", 32'(nb), 32'd2);
        check("withdraw_next", 32'(bus.gnt), 32'h2);

        // Zero weight acts as one beat per tenure, re-granted back-to-back.
        bus.req    = 4'b1000;
        bus.weight = {3'd0, 3'd1, 3'd1, 3'd1};
        bus.ack    = 1'b1;
        do_reset();
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("zw_beat", 32'(beat_owner), 32'd3);
            check("zw_idx",  32'(bus.gnt_idx), 32'd3);
        end

`ifdef WRR_LOCK_EN
        // Locked owner with weight 1 keeps the grant for 5 beats plus the releasing one.
        bus.req    = 4'b0011;
        bus.weight = {3'd1, 3'd1, 3'd1, 3'd1};
        bus.lock   = 4'b0001;
        bus.ack    = 1'b1;
        do_reset();
        cycle();
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt == 4'b0001) begin
                cycle();
                if (beat_owner == 0) nb++;
                if (nb == 5) bus.lock = 4'b0000;
            end
        end
        check("lock_beats", 32'(nb), 32'd6);
        check("lock_next",  32'(bus.gnt), 32'h2);
`endif

        // Random traffic against the model.
        bus.ack = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.req = 4'($urandom);
            bus.ack = 1'($urandom);
            if ($urandom_range(0, 7) == 0) bus.weight = 12'($urandom);
`ifdef WRR_LOCK_EN
            bus.lock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Weighted round-robin arbiter for NUM requesters sharing one downstream port.
- Successor to the single-cycle round-robin arbiter:
  - registered grant with per-requester weights (beats per tenure)
  - accept handshake from the downstream
  - back-to-back re-arbitration
- Sits between requester channels and a shared bus or memory port.

Parameters:
- NUM, 4: number of requesters; legal range 2..32.
- WEIGHT_W, 3: width of each per-requester weight field.
- IDX_W, $clog2(NUM): width of the grant index.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req  input  NUM  level request per requester; held until served
- weight  input  NUM*WEIGHT_W  per-requester beat budget; field i = weight[i*WEIGHT_W +: WEIGHT_W]
- ack  input  1  downstream accepts the current beat this cycle
- gnt  output  NUM  one-hot registered grant
- gnt_valid  output  1  some requester is granted (equals |gnt)
- gnt_idx  output  IDX_W  binary index of the granted requester
- lock  input  NUM  exists only with WRR_LOCK_EN

Behaviour:
- Reset: clk single clock domain; reset_n asynchronous, active-low, all state cleared asynchronously.
  - gnt=0, gnt_valid=0, gnt_idx=0, credit=0.
  - Priority pointer = one-hot bit 0; state IDLE.
- States: IDLE, GRANT.
- Pick function (combinational), applied to req with base = pointer:
  - Select the first set req bit at or above the base, wrapping around.
  - Yields one-hot result.
- IDLE: if |req, register the pick into gnt next edge and go to GRANT.
  - Load credit = weight[winner]; a weight of 0 is treated as 1.
  - Latency req→gnt is 1 cycle.
- GRANT, owner o:
  - A beat transfers when gnt[o] & req[o] & ack.
  - Each beat decrements credit.
- Release occurs when either:
  - a beat transfers with credit==1 (budget spent), or
  - req[o]==0 (owner withdrew; no beat that cycle).
- On release:
  - Pointer ← rotate-left(gnt), i.e. one past owner.
  - Re-pick in the same cycle using that new base on the current req, with the owner's bit masked if its budget was spent.
  - If a winner exists, load the new gnt and credit next edge (no idle gap).
  - Otherwise masked-out owner-only requests are still eligible, else gnt←0 and go to IDLE.
- Sole requester: with weight 2, it gets 2 beats, releases, and is immediately re-granted (continuous gnt, credit reloaded).
- ack while gnt_valid=0 is ignored.
- Mid-tenure weight changes do not affect the loaded credit.
- Credit counter is WEIGHT_W bits; it never underflows (reload on release).
- gnt_idx is a registered binary encode of gnt, updated on the same edge.
- Asynchronous reset mid-tenure drops gnt immediately; no beat counted.

Optional Feature:
- Macro WRR_LOCK_EN.
- Defined:
  - Adds input lock[NUM].
  - While lock[o]=1, budget exhaustion does not release; credit saturates at 1 and further beats are allowed.
  - Release happens on the first beat with lock[o]=0 and credit==1, or on req[o] drop.
  - Used for atomic bursts.
- Undefined: no lock port; behaviour as above.

Decomposition:
- Package wrr_pkg:
  - state enum {IDLE, GRANT}
  - function onehot2bin
  - function rotl1 (one-hot rotate)
- Sub-module rr_pick, parameter NUM, combinational:
  - Inputs: base, request. Output: one-hot pick.
  - Uses the doubled-request subtract-and-mask formulation.
  - Instantiated once inside wrr_arbiter.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle with req=4'b1111 → gnt=0 and gnt_valid=0 immediately; after release, first gnt=4'b0001 one cycle later.
- Weights: weights {1,2,3,1} (idx0..3), req=4'b1111, ack=1 continuously → owner sequence by beats: 0, 1,1, 2,2,2, 3, 0..., with no gap cycles.
- Backpressure: single req=4'b0100, weight 2, ack toggled 1,0,1 → 2 beats counted over 3 cycles; gnt stays 4'b0100 throughout; pointer then = 4'b1000.
- Withdrawal: owner 1 drops req after 1 of 3 beats, req2 pending → gnt=4'b0100 on the next edge; credit loaded from weight[2].
- Zero weight: weight[3]=0, req=4'b1000 only → 1 beat per tenure; re-granted back-to-back; gnt_idx=3 stable.
- WRR_LOCK_EN: weight[0]=1, lock[0]=1 for 5 beats, then 0 → 6 beats on requester 0 before gnt moves to the next requester.
